zombie_sprite_engine: RTL and testbench

//  Parametrised N-zombie sprite renderer for the VGA pixel path. Given DrawX/DrawY it finds the

---
 rtl/zombie_sprite_engine.sv | 175 +++++++++++++++++
 tb/tb_zombie_sprite_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zombie_sprite_engine.sv
// N-slot zombie sprite renderer: fixed-priority hit test, shared sprite ROM lookup,
// colour-key transparency and hit-flash tint, two-cycle registered pixel pipeline.
module zombie_sprite_engine #(
    parameter int          N_ZOMBIES    = 3,
    parameter int          SPRITE_SIZE  = 32,
    parameter int          N_FRAMES     = 2,
    parameter int          ANIM_DIV     = 8,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] KEY_COLOR    = 24'hFF00FF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_clk,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [10*N_ZOMBIES-1:0]   ZombieX,
    input  logic [10*N_ZOMBIES-1:0]   ZombieY,
    input  logic [2*N_ZOMBIES-1:0]    ZombieFace,
    input  logic [N_ZOMBIES-1:0]      ZombieAlive,
    input  logic [N_ZOMBIES-1:0]      ZombieHit,
    output logic                      is_zombie,
    output logic [2:0]                zombie_id,
    output logic [7:0]                SpriteR,
    output logic [7:0]                SpriteG,
    output logic [7:0]                SpriteB
);

    localparam int SW = $clog2(SPRITE_SIZE);
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int AW = 2 + FW + 2 * SW;
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int LW = $clog2(FLASH_FRAMES + 1);

    // Procedural sprite art: anti-diagonal texels are transparent, the rest encode
    // the address so every direction/frame/texel is distinguishable.
    function automatic logic [23:0] rom_word(input logic [AW-1:0] a);
        logic [SW:0] diag;
        diag = {1'b0, a[2*SW-1:SW]} + {1'b0, a[SW-1:0]};
        if (diag == (SW + 1)'(SPRITE_SIZE - 1))
            rom_word = KEY_COLOR;
        else
            rom_word = {a[7:0], 8'(a[AW-1:8]), a[7:0] ^ 8'hC3};
    endfunction

    // Frame strobe edge detect and animation state
    logic          frame_clk_q;
    logic          fe;
    logic [CW-1:0] anim_cnt_q, anim_cnt_d;
    logic [FW-1:0] anim_frame_q, anim_frame_d;
    logic [LW-1:0] flash_q [N_ZOMBIES];
    logic [LW-1:0] flash_d [N_ZOMBIES];

    assign fe = frame_clk & ~frame_clk_q;

    always_comb begin
        anim_cnt_d   = anim_cnt_q;
        anim_frame_d = anim_frame_q;
        if (fe) begin
            if (anim_cnt_q == CW'(ANIM_DIV - 1)) begin
                anim_cnt_d   = '0;
                anim_frame_d = (anim_frame_q == FW'(N_FRAMES - 1)) ? '0 : anim_frame_q + 1'b1;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    // A hit pulse always reloads, even when it lands on a frame strobe
    always_comb begin
        for (int i = 0; i < N_ZOMBIES; i++) begin
            flash_d[i] = flash_q[i];
            if (ZombieHit[i])
                flash_d[i] = LW'(FLASH_FRAMES);
            else if (fe && flash_q[i] != '0)
                flash_d[i] = flash_q[i] - 1'b1;
        end
    end

    // Stage 0: hit test and ROM address
    logic          hit0;
    logic [2:0]    id0;
    logic [1:0]    face0;
    logic          flash0;
    logic [SW-1:0] row0, col0;
    logic [AW-1:0] addr0;
    logic [10:0]   zx, zy, dx, dy;

    assign dx = {1'b0, DrawX};
    assign dy = {1'b0, DrawY};

    // Scan from the highest slot down so the lowest hitting index is the final writer
    always_comb begin
        hit0   = 1'b0;
        id0    = '0;
        face0  = '0;
        flash0 = 1'b0;
        row0   = '0;
        col0   = '0;
        zx     = '0;
        zy     = '0;
        for (int i = N_ZOMBIES - 1; i >= 0; i--) begin
            zx = {1'b0, ZombieX[10*i +: 10]};
            zy = {1'b0, ZombieY[10*i +: 10]};
            if (ZombieAlive[i] && dx >= zx && dx < zx + 11'(SPRITE_SIZE) &&
                dy >= zy && dy < zy + 11'(SPRITE_SIZE)) begin
                hit0   = 1'b1;
                id0    = 3'(i);
                face0  = ZombieFace[2*i +: 2];
                flash0 = (flash_q[i] != '0);
                col0   = DrawX[SW-1:0] - ZombieX[10*i +: SW];
                row0   = DrawY[SW-1:0] - ZombieY[10*i +: SW];
            end
        end
    end

    assign addr0 = hit0 ? {face0, anim_frame_q, row0, col0} : '0;

    // Stage 1: synchronous ROM read plus aligned side-band
    logic [23:0] rom_q;
    logic        hit1_q;
    logic [2:0]  id1_q;
    logic        flash1_q;

    // Stage 2: output registers
    logic        is_zombie_q, is_zombie_d;
    logic [2:0]  zombie_id_q, zombie_id_d;
    logic [23:0] rgb_q, rgb_d;

    // A keyed texel blanks the pixel outright; lower-priority slots do not show through
    always_comb begin
        is_zombie_d = 1'b0;
        zombie_id_d = '0;
        rgb_d       = 24'hFFFFFF;
        if (hit1_q && rom_q != KEY_COLOR) begin
            is_zombie_d = 1'b1;
            zombie_id_d = id1_q;
            rgb_d       = flash1_q ? {8'hFF, 1'b0, rom_q[15:9], 1'b0, rom_q[7:1]} : rom_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_clk_q  <= 1'b0;
            anim_cnt_q   <= '0;
            anim_frame_q <= '0;
            for (int i = 0; i < N_ZOMBIES; i++) flash_q[i] <= '0;
            rom_q        <= '0;
            hit1_q       <= 1'b0;
            id1_q        <= '0;
            flash1_q     <= 1'b0;
            is_zombie_q  <= 1'b0;
            zombie_id_q  <= '0;
            rgb_q        <= 24'hFFFFFF;
        end else begin
            frame_clk_q  <= frame_clk;
            anim_cnt_q   <= anim_cnt_d;
            anim_frame_q <= anim_frame_d;
            for (int i = 0; i < N_ZOMBIES; i++) flash_q[i] <= flash_d[i];
            rom_q        <= rom_word(addr0);
            hit1_q       <= hit0;
            id1_q        <= id0;
            flash1_q     <= flash0;
            is_zombie_q  <= is_zombie_d;
            zombie_id_q  <= zombie_id_d;
            rgb_q        <= rgb_d;
        end
    end

    assign is_zombie = is_zombie_q;
    assign zombie_id = zombie_id_q;
    assign SpriteR   = rgb_q[23:16];
    assign SpriteG   = rgb_q[15:8];
    assign SpriteB   = rgb_q[7:0];

endmodule

// File: tb/tb_zombie_sprite_engine.sv
// Bench for zombie_sprite_engine: pixel streams scored against a behavioural model
// of hit priority, sprite art, animation frame and flash tint.
module tb_zombie_sprite_engine;

    localparam int          N     = 3;
    localparam int          SZ    = 32;
    localparam int          ADIV  = 8;
    localparam int          FLASH = 8;
    localparam logic [23:0] KEY   = 24'hFF00FF;

    logic            Clk;
    logic            Reset_n;
    logic            frame_clk;
    logic [9:0]      DrawX, DrawY;
    logic [10*N-1:0] ZombieX, ZombieY;
    logic [2*N-1:0]  ZombieFace;
    logic [N-1:0]    ZombieAlive, ZombieHit;
    logic            is_zombie;
    logic [2:0]      zombie_id;
    logic [7:0]      SpriteR, SpriteG, SpriteB;

    zombie_sprite_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY),
        .ZombieX(ZombieX), .ZombieY(ZombieY), .ZombieFace(ZombieFace),
        .ZombieAlive(ZombieAlive), .ZombieHit(ZombieHit),
        .is_zombie(is_zombie), .zombie_id(zombie_id),
        .SpriteR(SpriteR), .SpriteG(SpriteG), .SpriteB(SpriteB)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [33:0] exp_q[$];
    int          px_q[$];
    int          py_q[$];

    // Model state
    int m_cnt = 0;
    int m_frame = 0;
    int m_flash[N];

    function automatic logic [23:0] m_rom(int face, int frame, int row, int col);
        logic [31:0] a;
        if (row + col == SZ - 1) return KEY;
        a = face * 2048 + frame * 1024 + row * 32 + col;
        return {a[7:0], a[15:8], a[7:0] ^ 8'hC3};
    endfunction

    function automatic logic [33:0] m_pixel(int x, int y);
        logic [23:0] t;
        int zx, zy;
        for (int i = 0; i < N; i++) begin
            zx = int'(ZombieX[10*i +: 10]);
            zy = int'(ZombieY[10*i +: 10]);
            if (ZombieAlive[i] && x >= zx && x < zx + SZ && y >= zy && y < zy + SZ) begin
                t = m_rom(int'(ZombieFace[2*i +: 2]), m_frame, y - zy, x - zx);
                if (t == KEY) return {1'b0, 3'd0, 24'hFFFFFF};
                if (m_flash[i] > 0) t = {8'hFF, 1'b0, t[15:9], 1'b0, t[7:1]};
                return {1'b1, 3'(i), t};
            end
        end
        return {1'b0, 3'd0, 24'hFFFFFF};
    endfunction

    function automatic logic [33:0] observed();
        return {is_zombie, is_zombie ? zombie_id : 3'd0, SpriteR, SpriteG, SpriteB};
    endfunction

    task automatic m_reset();
        m_cnt = 0;
        m_frame = 0;
        for (int i = 0; i < N; i++) m_flash[i] = 0;
    endtask

    task automatic m_rise();
        if (m_cnt == ADIV - 1) begin
            m_cnt = 0;
            m_frame = (m_frame + 1) % 2;
        end else begin
            m_cnt++;
        end
        for (int i = 0; i < N; i++) if (m_flash[i] > 0) m_flash[i]--;
    endtask

    task automatic set_zombie(int i, int x, int y, int face, bit alive);
        ZombieX[10*i +: 10]  = 10'(x);
        ZombieY[10*i +: 10]  = 10'(y);
        ZombieFace[2*i +: 2] = 2'(face);
        ZombieAlive[i]       = alive;
    endtask

    task automatic add_px(int x, int y);
        px_q.push_back(x);
        py_q.push_back(y);
    endtask

    // One pixel per cycle; result for the pixel driven two cycles earlier is scored first
    task automatic flush_px(string name);
        int n;
        logic [33:0] obs, expv;
        n = px_q.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge Clk);
            if (k >= 2) begin
                obs  = observed();
                expv = exp_q.pop_front();
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL %s px%0d (%0d,%0d): got %h expected %h",
                             name, k - 2, px_q[k-2], py_q[k-2], obs, expv);
                end
            end
            if (k < n) begin
                DrawX = 10'(px_q[k]);
                DrawY = 10'(py_q[k]);
                exp_q.push_back(m_pixel(px_q[k], py_q[k]));
            end
        end
        px_q.delete();
        py_q.delete();
    endtask

    task automatic frame_rise();
        @(negedge Clk);
        frame_clk = 1'b1;
        m_rise();
        @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    task automatic hit_pulse(logic [N-1:0] mask, bit with_rise);
        @(negedge Clk);
        ZombieHit = mask;
        if (with_rise) begin
            frame_clk = 1'b1;
            m_rise();
        end
        for (int i = 0; i < N; i++) if (mask[i]) m_flash[i] = FLASH;
        @(negedge Clk);
        ZombieHit = '0;
        frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] obs;
        set_zombie(0, 100, 50, 2, 1);
        DrawX = 10'd100;
        DrawY = 10'd50;
        Reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            ZombieHit = 3'($urandom_range(0, 7));
            frame_clk = 1'($urandom_range(0, 1));
            obs = {is_zombie, zombie_id, SpriteR, SpriteG, SpriteB};
            vectors++;
            if (obs !== {1'b0, 3'd0, 24'hFFFFFF}) begin
                miscompares++;
                $display("FAIL reset_hold c%0d: got %h expected %h", c, obs, {1'b0, 3'd0, 24'hFFFFFF});
            end
        end
        @(negedge Clk);
        ZombieHit = '0;
        frame_clk = 1'b0;
        Reset_n = 1'b1;
        m_reset();
        @(negedge Clk);
        obs = {is_zombie, zombie_id, SpriteR, SpriteG, SpriteB};
        vectors++;
        if (obs !== {1'b0, 3'd0, 24'hFFFFFF}) begin
            miscompares++;
            $display("FAIL reset_release1: got %h expected %h", obs, {1'b0, 3'd0, 24'hFFFFFF});
        end
        @(negedge Clk);
        obs = observed();
        vectors++;
        if (obs !== m_pixel(100, 50)) begin
            miscompares++;
            $display("FAIL reset_release2: got %h expected %h", obs, m_pixel(100, 50));
        end
    endtask

    task automatic test_basic();
        set_zombie(0, 100, 50, 2, 1);
        set_zombie(1, 600, 400, 0, 0);
        set_zombie(2, 700, 400, 0, 0);
        add_px(100, 50);  add_px(132, 50);  add_px(131, 81);  add_px(131, 50);
        add_px(100, 81);  add_px(99, 50);   add_px(100, 82);  add_px(100, 49);
        add_px(115, 66);
        flush_px("basic");
    endtask

    task automatic test_priority();
        set_zombie(0, 200, 200, 1, 1);
        set_zombie(1, 600, 400, 0, 1);
        set_zombie(2, 200, 200, 3, 1);
        add_px(210, 221); add_px(205, 205); add_px(605, 410);
        flush_px("priority_keyed");
        ZombieAlive[0] = 1'b0;
        add_px(210, 221); add_px(205, 205); add_px(231, 231);
        flush_px("priority_dead0");
    endtask

    task automatic test_edge();
        set_zombie(0, 10, 10, 0, 0);
        set_zombie(1, 1000, 300, 0, 1);
        set_zombie(2, 10, 10, 0, 0);
        add_px(5, 300);    add_px(5, 310);    add_px(1023, 300);
        add_px(1000, 331); add_px(999, 300);  add_px(1023, 331);
        flush_px("edge_wrap");
    endtask

    task automatic test_anim();
        set_zombie(0, 100, 50, 2, 1);
        set_zombie(1, 1000, 300, 0, 0);
        for (int r = 0; r < 7; r++) frame_rise();
        add_px(110, 60);
        flush_px("anim_r7");
        frame_rise();
        add_px(110, 60); add_px(100, 50);
        flush_px("anim_r8");
        for (int r = 0; r < 7; r++) frame_rise();
        add_px(110, 60);
        flush_px("anim_r15");
        frame_rise();
        add_px(110, 60); add_px(100, 50);
        flush_px("anim_r16");
    endtask

    task automatic test_flash();
        set_zombie(0, 100, 50, 2, 1);
        set_zombie(1, 300, 100, 1, 1);
        set_zombie(2, 700, 400, 0, 0);
        hit_pulse(3'b010, 0);
        add_px(310, 110); add_px(110, 60);
        flush_px("flash_start");
        for (int r = 1; r <= 8; r++) begin
            frame_rise();
            add_px(310, 110);
            flush_px($sformatf("flash_r%0d", r));
        end
        hit_pulse(3'b010, 0);
        for (int r = 1; r <= 5; r++) frame_rise();
        hit_pulse(3'b010, 0);
        for (int r = 1; r <= 8; r++) begin
            frame_rise();
            add_px(310, 110);
            flush_px($sformatf("reflash_r%0d", r));
        end
        hit_pulse(3'b010, 1);
        add_px(310, 110);
        flush_px("coinc_start");
        for (int r = 1; r <= 8; r++) begin
            frame_rise();
            add_px(310, 110);
            flush_px($sformatf("coinc_r%0d", r));
        end
    endtask

    task automatic test_reset_discard();
        hit_pulse(3'b010, 0);
        for (int r = 0; r < 3; r++) frame_rise();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        m_reset();
        add_px(310, 110); add_px(110, 60);
        flush_px("reset_discard");
    endtask

    task automatic test_back_to_back();
        for (int round = 0; round < 3; round++) begin
            set_zombie(0, 100, 50, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            set_zombie(1, $urandom_range(100, 300), $urandom_range(50, 110), $urandom_range(0, 3), 1);
            set_zombie(2, 120, 70, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 40; k++) add_px($urandom_range(90, 340), $urandom_range(40, 150));
            flush_px($sformatf("b2b_round%0d", round));
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        ZombieX     = '0;
        ZombieY     = '0;
        ZombieFace  = '0;
        ZombieAlive = '0;
        ZombieHit   = '0;
        m_reset();
        test_reset();
        test_basic();
        test_priority();
        test_edge();
        test_anim();
        test_flash();
        test_reset_discard();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
